// File: rtl/openddr_refresh_ctrl.sv
// openddr_refresh_ctrl: periodic DRAM refresh sequencer with postponement and PREA/REF strobes
// Ports:
//   mck, mc_rst_b            controller clock, asynchronous active-low reset
//   cfg_ref_en, cfg_trefi    refresh enable, interval in mck cycles (0 disables)
//   cfg_trp, cfg_trfc        precharge-to-refresh and refresh-to-next-command waits
//   bus_busy, ref_gnt        scheduler traffic indication and bus grant
//   ref_req, ref_urgent      bus request, postponement limit nearly reached
//   ref_active               refresh owns the command bus
//   pre_all_cmd, ref_cmd     one-cycle PRECHARGE-ALL / REFRESH strobes
//   pending_cnt, ref_ovf     outstanding refreshes, sticky lost-tick flag
// Optional: OPENDDR_REF_STATS_EN adds stat_ref_cnt and stat_urgent_cnt.
module openddr_refresh_ctrl #(
  parameter int MAX_POSTPONE = 8,
  parameter int TREFI_W = 16,
  parameter int TRFC_W = 10,
  parameter int TRP_W = 8
) (
  input  logic               mck,
  input  logic               mc_rst_b,
  input  logic               cfg_ref_en,
  input  logic [TREFI_W-1:0] cfg_trefi,
  input  logic [TRP_W-1:0]   cfg_trp,
  input  logic [TRFC_W-1:0]  cfg_trfc,
  input  logic               bus_busy,
  input  logic               ref_gnt,
  output logic               ref_req,
  output logic               ref_urgent,
  output logic               ref_active,
  output logic               pre_all_cmd,
  output logic               ref_cmd,
  output logic [3:0]         pending_cnt,
`ifdef OPENDDR_REF_STATS_EN
  output logic [31:0]        stat_ref_cnt,
  output logic [15:0]        stat_urgent_cnt,
`endif
  output logic               ref_ovf
);
  localparam int WW = (TRFC_W > TRP_W) ? TRFC_W : TRP_W;
  localparam logic [3:0] MAXP = 4'(MAX_POSTPONE);
  typedef enum logic [2:0] {IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC} state_t;
  state_t state_q, state_d;
  logic [TREFI_W-1:0] intv_q, intv_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [3:0] pend_q, pend_d;
  logic ovf_q, ovf_d, req_q, req_d, act_q, act_d, pre_q, pre_d, refc_q, refc_d;
  logic ref_en, tick, inc, urgent, go, wdone;
  always_comb begin
    ref_en = cfg_ref_en && (cfg_trefi != '0);
    tick = ref_en && (intv_q == '0);
    intv_d = !ref_en ? '0 : tick ? cfg_trefi - TREFI_W'(1) : intv_q - TREFI_W'(1);
    // a tick coinciding with a refresh is never lost, even at saturation
    inc = tick && ((pend_q != MAXP) || refc_q);
    pend_d = pend_q + 4'(inc) - 4'(refc_q);
    ovf_d = ovf_q || (tick && (pend_q == MAXP) && !refc_q);
    urgent = pend_q >= (MAXP - 4'd1);
    go = (pend_q != '0) && (urgent || !bus_busy);
    // waits last max(cfg,1) cycles so gnt->ref_cmd is cfg_trp+2
    wdone = wcnt_q <= WW'(1);
    state_d = state_q;
    wcnt_d = (wcnt_q == '0) ? '0 : wcnt_q - WW'(1);
    case (state_q)
      IDLE:     state_d = (go && cfg_ref_en) ? REQ : IDLE;
      REQ:      state_d = !cfg_ref_en ? IDLE : ref_gnt ? PRE : REQ;
      PRE: begin
        state_d = WAIT_RP;
        wcnt_d = WW'(cfg_trp);
      end
      WAIT_RP:  state_d = wdone ? REF : WAIT_RP;
      REF: begin
        state_d = WAIT_RFC;
        wcnt_d = WW'(cfg_trfc);
      end
      WAIT_RFC: state_d = !wdone ? WAIT_RFC : go ? PRE : IDLE;
      default:  state_d = IDLE;
    endcase
    req_d = state_d == REQ;
    act_d = state_d inside {PRE, WAIT_RP, REF, WAIT_RFC};
    pre_d = state_d == PRE;
    refc_d = state_d == REF;
  end
  always_ff @(posedge mck or negedge mc_rst_b) begin
    if (!mc_rst_b) begin
      state_q <= IDLE;
      intv_q <= '0;
      wcnt_q <= '0;
      pend_q <= '0;
      ovf_q <= 1'b0;
      req_q <= 1'b0;
      act_q <= 1'b0;
      pre_q <= 1'b0;
      refc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      intv_q <= intv_d;
      wcnt_q <= wcnt_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      req_q <= req_d;
      act_q <= act_d;
      pre_q <= pre_d;
      refc_q <= refc_d;
    end
  end
  assign ref_req = req_q;
  assign ref_urgent = urgent;
  assign ref_active = act_q;
  assign pre_all_cmd = pre_q;
  assign ref_cmd = refc_q;
  assign pending_cnt = pend_q;
  assign ref_ovf = ovf_q;
`ifdef OPENDDR_REF_STATS_EN
  logic [31:0] sref_q, sref_d;
  logic [15:0] surg_q, surg_d;
  always_comb begin
    sref_d = sref_q + 32'(refc_q);
    surg_d = surg_q + 16'((state_q == IDLE) && (state_d == REQ) && urgent);
  end
  always_ff @(posedge mck or negedge mc_rst_b) begin
    if (!mc_rst_b) begin
      sref_q <= '0;
      surg_q <= '0;
    end else begin
      sref_q <= sref_d;
      surg_q <= surg_d;
    end
  end
  assign stat_ref_cnt = sref_q;
  assign stat_urgent_cnt = surg_q;
`endif
endmodule

// File: tb/tb_openddr_refresh_ctrl.sv
// tb_openddr_refresh_ctrl: directed table and sequence checks for openddr_refresh_ctrl
module tb_openddr_refresh_ctrl;
  logic mck = 1'b0;
  logic mc_rst_b = 1'b0;
  logic cfg_ref_en = 1'b0;
  logic bus_busy = 1'b0;
  logic ref_gnt = 1'b0;
  logic [15:0] cfg_trefi = '0;
  logic [7:0] cfg_trp = '0;
  logic [9:0] cfg_trfc = '0;
  logic ref_req, ref_urgent, ref_active, pre_all_cmd, ref_cmd, ref_ovf;
  logic [3:0] pending_cnt;
`ifdef OPENDDR_REF_STATS_EN
  logic [31:0] stat_ref_cnt;
  logic [15:0] stat_urgent_cnt;
`endif
  int n_err = 0;
  int n_chk = 0;
  int rt[4];
  int pt[4];
  typedef struct {
    logic [7:0] trp;
    logic [9:0] trfc;
    int pre2ref;
    int ref2idle;
  } vec_t;
  vec_t vt[5];
  openddr_refresh_ctrl dut (
    .mck(mck), .mc_rst_b(mc_rst_b), .cfg_ref_en(cfg_ref_en), .cfg_trefi(cfg_trefi),
    .cfg_trp(cfg_trp), .cfg_trfc(cfg_trfc), .bus_busy(bus_busy), .ref_gnt(ref_gnt),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_active(ref_active),
    .pre_all_cmd(pre_all_cmd), .ref_cmd(ref_cmd), .pending_cnt(pending_cnt),
`ifdef OPENDDR_REF_STATS_EN
    .stat_ref_cnt(stat_ref_cnt), .stat_urgent_cnt(stat_urgent_cnt),
`endif
    .ref_ovf(ref_ovf)
  );
  always #5 mck = ~mck;
  task automatic step;
    @(posedge mck);
    #1;
  endtask
  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int outs();
    return int'({ref_req, ref_urgent, ref_active, pre_all_cmd, ref_cmd, ref_ovf, pending_cnt});
  endfunction
  task automatic do_reset;
    mc_rst_b = 1'b0;
    cfg_ref_en = 1'b0;
    cfg_trefi = '0;
    cfg_trp = '0;
    cfg_trfc = '0;
    bus_busy = 1'b0;
    ref_gnt = 1'b0;
    #1;
    check("reset_outputs", outs(), 0);
    step;
    step;
    mc_rst_b = 1'b1;
  endtask
  task automatic setup(input int trefi, input int trp, input int trfc, input logic busy, input logic gnt);
    do_reset;
    cfg_ref_en = 1'b1;
    cfg_trefi = 16'(trefi);
    cfg_trp = 8'(trp);
    cfg_trfc = 10'(trfc);
    bus_busy = busy;
    ref_gnt = gnt;
  endtask
  initial begin
    int n, np, pre_at, ref_at, idle_at;
    bit started, found;
    vt[0] = '{8'd3, 10'd10, 4, 11};
    vt[1] = '{8'd0, 10'd0, 2, 2};
    vt[2] = '{8'd1, 10'd1, 2, 2};
    vt[3] = '{8'd5, 10'd2, 6, 3};
    vt[4] = '{8'd2, 10'd20, 3, 21};
    for (int i = 0; i < 5; i++) begin
      setup(1000, int'(vt[i].trp), int'(vt[i].trfc), 1'b0, 1'b1);
      pre_at = -1;
      ref_at = -1;
      idle_at = -1;
      n = 0;
      for (int c = 1; c <= 200; c++) begin
        step;
        if (pre_all_cmd && pre_at < 0) pre_at = c;
        if (ref_cmd) begin
          n++;
          ref_at = c;
        end
        if (ref_at > 0 && !ref_active) begin
          idle_at = c;
          break;
        end
      end
      check($sformatf("vec%0d_pre_to_ref", i), ref_at - pre_at, vt[i].pre2ref);
      check($sformatf("vec%0d_ref_to_idle", i), idle_at - ref_at, vt[i].ref2idle);
      check($sformatf("vec%0d_ref_count", i), n, 1);
      check($sformatf("vec%0d_pending", i), int'(pending_cnt), 0);
    end
    setup(100, 3, 10, 1'b0, 1'b1);
    n = 0;
    np = 0;
    for (int c = 1; c <= 320; c++) begin
      step;
      if (pre_all_cmd && np < 4) begin
        pt[np] = c;
        np++;
      end
      if (ref_cmd && n < 4) begin
        rt[n] = c;
        n++;
      end
      if (c == 300) check("t1_pending_drained", int'(pending_cnt), 0);
    end
    check("t1_ref_count", n, 4);
    check("t1_first_ref", rt[0], 7);
    check("t1_period_a", rt[1] - rt[0], 100);
    check("t1_period_b", rt[2] - rt[1], 100);
    check("t1_pre_to_ref", rt[0] - pt[0], 4);
    setup(100, 3, 4, 1'b1, 1'b0);
    for (int c = 1; c <= 610; c++) begin
      step;
      if (c == 600) check("t2_before_urgent", int'({ref_req, ref_urgent, pending_cnt}), 6);
      if (c == 602) check("t2_urgent_req", int'({ref_req, ref_urgent, pending_cnt}), 'h37);
    end
    bus_busy = 1'b0;
    ref_gnt = 1'b1;
    step;
    check("t2_req_drop_pre", int'({ref_req, pre_all_cmd}), 1);
    n = 0;
    np = 1;
    started = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (ref_active) started = 1'b1;
      if (started && !ref_active) break;
      step;
      if (pre_all_cmd) np++;
      if (ref_cmd) n++;
    end
    check("t2_drain_refs", n, 7);
    check("t2_drain_pres", np, 7);
    check("t2_pending", int'(pending_cnt), 0);
`ifdef OPENDDR_REF_STATS_EN
    check("t2_stat_urgent", int'(stat_urgent_cnt), 1);
    check("t2_stat_ref", int'(stat_ref_cnt), 7);
`endif
    setup(100, 3, 10, 1'b0, 1'b0);
    for (int c = 1; c <= 805; c++) begin
      step;
      if (c == 750) check("t3_saturated", int'({ref_req, ref_urgent, ref_ovf, pending_cnt}), 'h68);
      if (c == 805) check("t3_overflow", int'({ref_req, ref_urgent, ref_ovf, pending_cnt}), 'h78);
    end
    cfg_ref_en = 1'b0;
    step;
    check("t3_req_dropped", int'(ref_req), 0);
    step;
    check("t3_pending_kept", int'({ref_req, ref_ovf, pending_cnt}), 'h18);
    setup(100, 3, 10, 1'b1, 1'b1);
    for (int c = 1; c <= 301; c++) begin
      step;
      if (c == 294) bus_busy = 1'b0;
      if (c == 300) check("t4_ref_at_3", int'({ref_cmd, pending_cnt}), 'h13);
      if (c == 301) check("t4_tick_and_ref", int'(pending_cnt), 3);
    end
    setup(3, 3, 10, 1'b1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step;
      found = ref_cmd;
    end
    check("t5_ref_seen", int'(found), 1);
    step;
    step;
    check("t5_in_rfc", int'(ref_active && pending_cnt != 0), 1);
    #2;
    mc_rst_b = 1'b0;
    #1;
    check("t5_async_clear", outs(), 0);
    step;
    cfg_ref_en = 1'b0;
    mc_rst_b = 1'b1;
    step;
    step;
    check("t5_after_release", int'(pending_cnt), 0);
    setup(20, 3, 10, 1'b0, 1'b1);
    n = 0;
    np = 0;
    for (int c = 1; c <= 200; c++) begin
      step;
      if (c == 4) cfg_ref_en = 1'b0;
      if (pre_all_cmd) np++;
      if (ref_cmd) n++;
    end
    check("t6_ref_once", n, 1);
    check("t6_pre_once", np, 1);
    check("t6_idle", int'({ref_active, ref_req, pending_cnt}), 0);
`ifdef OPENDDR_REF_STATS_EN
    check("t6_stat_ref", int'(stat_ref_cnt), 1);
`endif
    setup(0, 3, 10, 1'b0, 1'b1);
    n = 0;
    for (int c = 1; c <= 50; c++) begin
      step;
      if (ref_cmd || pending_cnt != 0) n++;
    end
    check("t7_trefi_zero_idle", n, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
